// File: rtl/lemv8_pkg.sv
// Shared constants for the LEGv8 fetch stage: state encoding, PC step and opcode field bounds.
package lemv8_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam int unsigned PC_INCR = 4;
  localparam int unsigned OPC_HI  = 31;
  localparam int unsigned OPC_LO  = 21;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: sequential PC+4, unconditional branch, or CBZ-taken branch.
module next_pc_logic
  import lemv8_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 64
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] branch_offset,
  input  logic                branch,
  input  logic                uncond_branch,
  input  logic                zero,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic                taken;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] seq_pc;

  // Offset is in words; wrap-around of either sum is intentional.
  assign taken   = uncond_branch | (branch & zero);
  assign target  = pc + (branch_offset << 2);
  assign seq_pc  = pc + PC_WIDTH'(PC_INCR);
  assign next_pc = taken ? target : seq_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from a variable-latency memory and holds the
// instruction until the datapath signals completion, then commits the next PC.
module fetch_unit
  import lemv8_pkg::*;
#(
  parameter int unsigned          PC_WIDTH    = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
  parameter int unsigned          INSTR_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   resetl,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [10:0]            opcode,
  output logic                   instr_valid,
  output logic [PC_WIDTH-1:0]    pc_out,
  input  logic                   ex_done,
  input  logic                   branch,
  input  logic                   uncond_branch,
  input  logic                   zero,
  input  logic [PC_WIDTH-1:0]    branch_offset,
  output logic [31:0]            retired_count
);

  logic [1:0]             state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   req_q, req_d;
  logic [31:0]            retired_q;
  logic                   commit;
  logic [PC_WIDTH-1:0]    next_pc;

  next_pc_logic #(
    .PC_WIDTH (PC_WIDTH)
  ) u_next_pc (
    .pc            (pc_q),
    .branch_offset (branch_offset),
    .branch        (branch),
    .uncond_branch (uncond_branch),
    .zero          (zero),
    .next_pc       (next_pc)
  );

  // Each input only acts in the one state where it is meaningful.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        req_d   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ex_done) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      retired_q <= '0;
    end else if (commit) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign instruction   = instr_q;
  assign opcode        = instr_q[OPC_HI:OPC_LO];
  assign instr_valid   = valid_q;
  assign pc_out        = pc_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of fetch/commit vectors plus reset corner sequences.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        resetl = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction;
  logic [10:0] opcode;
  logic        instr_valid;
  logic [63:0] pc_out;
  logic        ex_done = 1'b0;
  logic        branch = 1'b0;
  logic        uncond_branch = 1'b0;
  logic        zero = 1'b0;
  logic [63:0] branch_offset = '0;
  logic [31:0] retired_count;

  fetch_unit #(
    .PC_WIDTH    (64),
    .RESET_PC    (64'h0),
    .INSTR_WIDTH (32)
  ) dut (
    .CLK           (CLK),
    .resetl        (resetl),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .opcode        (opcode),
    .instr_valid   (instr_valid),
    .pc_out        (pc_out),
    .ex_done       (ex_done),
    .branch        (branch),
    .uncond_branch (uncond_branch),
    .zero          (zero),
    .branch_offset (branch_offset),
    .retired_count (retired_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rdata;
    logic [10:0] opc;
    int          lat;
    logic        spur;
    logic        br;
    logic        ub;
    logic        z;
    logic [63:0] off;
    logic [63:0] pc;
    logic [63:0] nxt;
    logic        wrap;
  } vec_t;

  vec_t        vecs[12];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_ret  = '0;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Entered with the DUT in IDLE, one cycle before it should raise imem_req.
  task automatic run_instr(input vec_t v);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("req_latency", 64'(n), 64'd1);
    check("imem_addr", imem_addr, v.pc);
    for (int c = 0; c < v.lat; c++) begin
      if (v.spur) begin
        ex_done       = 1'b1;
        uncond_branch = 1'b1;
        branch_offset = 64'h100;
      end
      step();
      ex_done       = 1'b0;
      uncond_branch = 1'b0;
      if (v.spur) begin
        check("wait_valid_low", 64'(instr_valid), 64'd0);
        check("wait_addr_stable", imem_addr, v.pc);
      end
    end
    imem_ready = 1'b1;
    imem_rdata = v.rdata;
    step();
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check("instr_valid", 64'(instr_valid), 64'd1);
    check("instruction", 64'(instruction), 64'(v.rdata));
    check("opcode", 64'(opcode), 64'(v.opc));
    check("pc_out", pc_out, v.pc);
    if (v.spur) begin
      for (int c = 0; c < 3; c++) begin
        imem_ready = 1'b1;
        imem_rdata = ~v.rdata;
        step();
        check("hold_instr_stable", 64'(instruction), 64'(v.rdata));
        check("hold_valid", 64'(instr_valid), 64'd1);
      end
      imem_ready = 1'b0;
    end
    if (v.wrap) begin
      force dut.retired_q = 32'hFFFF_FFFF;
      #1;
      release dut.retired_q;
      exp_ret = 32'hFFFF_FFFF;
    end
    ex_done       = 1'b1;
    branch        = v.br;
    uncond_branch = v.ub;
    zero          = v.z;
    branch_offset = v.off;
    step();
    ex_done       = 1'b0;
    branch        = 1'b0;
    uncond_branch = 1'b0;
    zero          = 1'b0;
    branch_offset = 64'hA5A5_A5A5_A5A5_A5A5;
    exp_ret       = exp_ret + 32'd1;
    check("commit_valid_low", 64'(instr_valid), 64'd0);
    check("next_pc", imem_addr, v.nxt);
    check("retired_count", 64'(retired_count), 64'(exp_ret));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    //             rdata         opc     lat spur br    ub    z     off                     pc                      nxt                     wrap
    vecs[0]  = '{32'h8B020020, 11'h458, 1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                 64'h0,                 64'h4,                 1'b0};
    vecs[1]  = '{32'hF8400020, 11'h7C2, 0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd15,                64'h4,                 64'h40,                1'b0};
    vecs[2]  = '{32'h14000000, 11'h0A0, 1, 1'b0, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h40,              64'h38,                1'b0};
    vecs[3]  = '{32'h17FFFFF6, 11'h0BF, 2, 1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF6, 64'h38,              64'h10,                1'b0};
    vecs[4]  = '{32'hB4000060, 11'h5A0, 1, 1'b0, 1'b1, 1'b0, 1'b1, 64'd3,                 64'h10,                64'h1C,                1'b0};
    vecs[5]  = '{32'h17FFFFFD, 11'h0BF, 1, 1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'h1C,              64'h10,                1'b0};
    vecs[6]  = '{32'hB4000060, 11'h5A0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd3,                 64'h10,                64'h14,                1'b0};
    vecs[7]  = '{32'h8B020020, 11'h458, 5, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                 64'h14,                64'h18,                1'b0};
    vecs[8]  = '{32'hCB010000, 11'h658, 1, 1'b0, 1'b0, 1'b0, 1'b1, 64'd100,               64'h18,                64'h1C,                1'b0};
    vecs[9]  = '{32'h17FFFFF8, 11'h0BF, 1, 1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1C,              64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vecs[10] = '{32'hD503201F, 11'h6A8, 3, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'hFFFF_FFFF_FFFF_FFFC, 64'h0,                 1'b1};
    vecs[11] = '{32'h14000005, 11'h0A0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd5,                 64'h0,                 64'h14,                1'b0};

    resetl = 1'b0;
    repeat (2) step();
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_instruction", 64'(instruction), 64'd0);
    check("rst_opcode", 64'(opcode), 64'd0);
    check("rst_retired", 64'(retired_count), 64'd0);
    check("rst_pc", imem_addr, 64'h0);
    resetl = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_instr(vecs[i]);
    end

    // Reset while a fetch is outstanding, with a response in the same and following cycle.
    step();
    check("pre_rst_req", 64'(imem_req), 64'd1);
    check("pre_rst_addr", imem_addr, 64'h14);
    resetl     = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h8B020020;
    step();
    resetl = 1'b1;
    check("wait_rst_valid", 64'(instr_valid), 64'd0);
    check("wait_rst_req", 64'(imem_req), 64'd0);
    check("wait_rst_pc", imem_addr, 64'h0);
    check("wait_rst_retired", 64'(retired_count), 64'd0);
    step();
    imem_ready = 1'b0;
    check("post_rst_valid", 64'(instr_valid), 64'd0);
    check("post_rst_req", 64'(imem_req), 64'd1);
    check("post_rst_addr", imem_addr, 64'h0);
    step();
    imem_ready = 1'b1;
    imem_rdata = 32'hCB010000;
    step();
    imem_ready = 1'b0;
    check("post_rst_fetch_valid", 64'(instr_valid), 64'd1);
    check("post_rst_fetch_instr", 64'(instruction), 64'hCB010000);

    // Reset in HOLD together with ex_done: no commit.
    resetl        = 1'b0;
    ex_done       = 1'b1;
    uncond_branch = 1'b1;
    branch_offset = 64'd5;
    step();
    resetl        = 1'b1;
    ex_done       = 1'b0;
    uncond_branch = 1'b0;
    check("hold_rst_valid", 64'(instr_valid), 64'd0);
    check("hold_rst_retired", 64'(retired_count), 64'd0);
    check("hold_rst_pc", imem_addr, 64'h0);
    exp_ret = '0;
    run_instr(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage for the single-cycle LEGv8 datapath.
- Owns the PC, requests instructions from a variable-latency instruction memory, and holds each instruction stable while the datapath executes it.
- Presents opcode bits [31:21] to the control decoder.
- On execute-complete, applies next-PC selection (PC+4, unconditional branch, CBZ-taken) from control and ALU results.

Parameters:
- PC_WIDTH, 64, width of PC and address path.
- RESET_PC, 64'h0, PC value loaded on reset.
- INSTR_WIDTH, 32, instruction word width (fixed 32; parameter for documentation only).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- resetl  in  1  synchronous active-low reset.
- imem_req  out  1  request strobe; one-cycle pulse per fetch.
- imem_addr  out  PC_WIDTH  fetch address (current PC), valid while imem_req=1.
- imem_ready  in  1  response valid; qualifies imem_rdata.
- imem_rdata  in  32  returned instruction.
- instruction  out  32  held instruction word.
- opcode  out  11  instruction[31:21], to control decoder.
- instr_valid  out  1  instruction/opcode valid for execution.
- pc_out  out  PC_WIDTH  PC of held instruction.
- ex_done  in  1  datapath finished the held instruction; commit next PC.
- branch  in  1  from control (CBZ).
- uncond_branch  in  1  from control (B).
- zero  in  1  ALU zero flag.
- branch_offset  in  PC_WIDTH  sign-extended word offset from sign-extend unit (not yet shifted).
- retired_count  out  32  instructions committed since reset.

Behaviour:
- Reset (resetl=0 at a CLK edge):
  - PC=RESET_PC, state=IDLE.
  - imem_req=0, instr_valid=0, instruction=0, opcode=0, retired_count=0.
  - Reset dominates every other input in the same cycle.
- States:
  - IDLE: next cycle assert imem_req=1, imem_addr=PC; go to WAIT.
  - WAIT: imem_req=0. On imem_ready=1, latch imem_rdata into instruction, set instr_valid=1, go to HOLD. Otherwise stay; no timeout.
  - HOLD: instruction, opcode and pc_out are stable. On ex_done=1:
    - PC <= next_pc; instr_valid <= 0; retired_count++; go to IDLE.
- next_pc rule:
  - If uncond_branch=1, or branch=1 and zero=1: PC + (branch_offset << 2).
  - Otherwise: PC + 4.
  - uncond_branch takes priority over branch.
  - Arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
- Latency:
  - Fetch-to-valid = 2 + memory latency. With imem_ready asserted the cycle after the request, instr_valid rises 2 cycles after leaving IDLE.
  - Minimum instruction period = 3 cycles (IDLE, WAIT, HOLD with ex_done).
- Ignored inputs:
  - imem_ready outside WAIT is ignored (stale or spurious).
  - ex_done outside HOLD is ignored.
  - branch, zero, uncond_branch, branch_offset are sampled only on the ex_done cycle in HOLD. X on them elsewhere is legal.
- imem_ready and ex_done in the same cycle: only the input legal for the current state acts.
- opcode is combinationally instruction[31:21]. It must not change while instr_valid=1.
- retired_count wraps at 2^32.
- Reset mid-fetch (in WAIT): the outstanding request is abandoned. The instruction memory shares resetl and drops its response; any imem_ready arriving in the cycle after reset is ignored because state is IDLE.
- Reset in HOLD: the held instruction is discarded without commit; retired_count does not increment.

Decomposition:
- Shared package lemv8_pkg:
  - Fetch state encoding, IDLE=2'd0, WAIT=2'd1, HOLD=2'd2.
  - PC_INCR=4.
  - Opcode field bounds OPC_HI=31, OPC_LO=21.
- Sub-module next_pc_logic (combinational): inputs PC, branch_offset, branch, uncond_branch, zero; output next_pc. It is natural and reusable by a later pipelined datapath.

Test Plan:
- Reset then release, memory latency 1, rdata=32'h8B020020 (ADD) → imem_addr=0 on cycle 1; instr_valid=1 on cycle 3; opcode=11'h458; pc_out=0; after ex_done, next imem_addr=4.
- HOLD with uncond_branch=1, branch_offset=64'hFFFF_FFFF_FFFF_FFFE, PC=0x40, ex_done=1 → next imem_addr=0x38; retired_count+1.
- CBZ: branch=1, offset=3, PC=0x10 → zero=1 gives next addr 0x1C; repeat with zero=0 gives 0x14.
- Memory latency 5 cycles with spurious imem_ready pulses in HOLD and ex_done pulses in WAIT → no state change from spurious pulses; instruction is unchanged until commit.
- resetl=0 asserted in WAIT with imem_ready=1 in that same cycle → instr_valid stays 0; PC=RESET_PC; the first request after reset targets RESET_PC.
- PC=64'hFFFF_FFFF_FFFF_FFFC, no branch, ex_done → next imem_addr=0 (wrap); retired_count at 32'hFFFF_FFFF wraps to 0.
